// File: rtl/spi_flash_bridge.sv
// spi_flash_bridge: CPU byte-bus responder that turns reads/writes into SPI NOR flash transactions
module spi_flash_bridge #(
    parameter int CLK_DIV  = 2,
    parameter int CS_GAP   = 4,
    parameter int POLL_MAX = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        oe_,
    input  logic        we_,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        rdata_oe,
    output logic        busy,
    output logic        err,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n
);
    localparam int CW = $clog2((CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP) + 1);
    localparam int PW = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {IDLE, RD_XFER, WREN_XFER, GAP1, PP_XFER, GAP2, POLL_XFER, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    bit_q, bit_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [39:0]   tx_q, tx_d;
    logic [23:0]   pp_q, pp_d;
    logic [7:0]    rx_q, rx_d, rdata_q, rdata_d;
    logic          oe_q, oe_d, we_q, we_d, rd_q, rd_d;
    logic          rdata_oe_q, rdata_oe_d, busy_q, busy_d, err_q, err_d;
    logic          sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
    logic [5:0]    nbits;
    logic          tick, gap_end, poll_last;

    assign nbits     = state_q == WREN_XFER ? 6'd8 : state_q == POLL_XFER ? 6'd16 : 6'd40;
    assign tick      = cnt_q == CW'(CLK_DIV - 1);
    assign gap_end   = cnt_q == CW'(CS_GAP - 1);
    assign poll_last = poll_q >= PW'(POLL_MAX - 1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        poll_d     = poll_q;
        tx_d       = tx_q;
        pp_d       = pp_q;
        rx_d       = rx_q;
        rdata_d    = rdata_q;
        rd_d       = rd_q;
        rdata_oe_d = rdata_oe_q;
        busy_d     = busy_q;
        err_d      = err_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        oe_d       = oe_;
        we_d       = we_;
        case (state_q)
            IDLE: begin
                rdata_oe_d = rdata_oe_q & ~oe_ & we_;
                // start only on a falling edge of exactly one strobe
                if ((oe_q & ~oe_ & we_) | (we_q & ~we_ & oe_)) begin
                    rd_d       = ~oe_;
                    pp_d       = {addr, wdata};
                    tx_d       = ~oe_ ? {8'h03, 8'h00, addr, 8'h00} : {8'h06, 32'h0};
                    state_d    = ~oe_ ? RD_XFER : WREN_XFER;
                    mosi_d     = tx_d[39];
                    busy_d     = 1'b1;
                    cs_n_d     = 1'b0;
                    rdata_oe_d = 1'b0;
                    cnt_d      = '0;
                    bit_d      = '0;
                    poll_d     = '0;
                end
            end
            RD_XFER, WREN_XFER, PP_XFER, POLL_XFER: begin
                if (bit_q == nbits) begin
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    cnt_d   = '0;
                    rdata_d = state_q == RD_XFER ? rx_q : rdata_q;
                    poll_d  = state_q == POLL_XFER && poll_q != PW'(POLL_MAX) ? poll_q + 1'b1 : poll_q;
                    err_d   = err_q | (state_q == POLL_XFER && rx_q[0] && poll_last);
                    state_d = state_q == RD_XFER ? DONE : state_q == WREN_XFER ? GAP1 :
                              state_q == PP_XFER ? GAP2 : (!rx_q[0] || poll_last) ? DONE : GAP2;
                end else begin
                    cnt_d = tick ? '0 : cnt_q + 1'b1;
                    if (tick) begin
                        sclk_d = ~sclk_q;
                        rx_d   = sclk_q ? rx_q : {rx_q[6:0], miso};
                        bit_d  = sclk_q ? bit_q + 1'b1 : bit_q;
                        tx_d   = sclk_q ? tx_q << 1 : tx_q;
                        mosi_d = sclk_q ? tx_q[38] : mosi_q;
                    end
                end
            end
            GAP1, GAP2: begin
                cnt_d = cnt_q + 1'b1;
                if (gap_end) begin
                    tx_d    = state_q == GAP1 ? {8'h02, 8'h00, pp_q} : {8'h05, 32'h0};
                    state_d = state_q == GAP1 ? PP_XFER : POLL_XFER;
                    mosi_d  = tx_d[39];
                    cs_n_d  = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            DONE: begin
                busy_d     = 1'b0;
                rdata_oe_d = rd_q & ~oe_ & we_;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            poll_q     <= '0;
            tx_q       <= '0;
            pp_q       <= '0;
            rx_q       <= '0;
            rdata_q    <= '0;
            rd_q       <= 1'b0;
            oe_q       <= 1'b1;
            we_q       <= 1'b1;
            rdata_oe_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            poll_q     <= poll_d;
            tx_q       <= tx_d;
            pp_q       <= pp_d;
            rx_q       <= rx_d;
            rdata_q    <= rdata_d;
            rd_q       <= rd_d;
            oe_q       <= oe_d;
            we_q       <= we_d;
            rdata_oe_q <= rdata_oe_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
        end
    end

    assign rdata    = rdata_q;
    assign rdata_oe = rdata_oe_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
endmodule

// File: tb/tb_spi_flash_bridge.sv
// tb_spi_flash_bridge: directed + randomized checks of the SPI flash bridge against a behavioural flash model
module tb_spi_flash_bridge;
    localparam int PER = 10;

    logic        clk = 1'b0, rst = 1'b1, sel = 1'b0, miso = 1'b0;
    logic [1:0]  oen = 2'b11, wen = 2'b11;
    logic [15:0] addr_r = '0;
    logic [7:0]  wdata_r = '0;
    logic [7:0]  rdata0, rdata1;
    logic [1:0]  rdoe, busy, err, sclk, mosi, csn;
    int          nvec = 0, nerr = 0, viol = 0;

    always #(PER/2) clk = ~clk;

    spi_flash_bridge #(.CLK_DIV(2), .CS_GAP(4), .POLL_MAX(4)) dut0 (
        .clk(clk), .rst(rst), .oe_(oen[0]), .we_(wen[0]), .addr(addr_r), .wdata(wdata_r),
        .rdata(rdata0), .rdata_oe(rdoe[0]), .busy(busy[0]), .err(err[0]),
        .sclk(sclk[0]), .mosi(mosi[0]), .miso(miso), .cs_n(csn[0]));

    spi_flash_bridge #(.CLK_DIV(1), .CS_GAP(4), .POLL_MAX(4096)) dut1 (
        .clk(clk), .rst(rst), .oe_(oen[1]), .we_(wen[1]), .addr(addr_r), .wdata(wdata_r),
        .rdata(rdata1), .rdata_oe(rdoe[1]), .busy(busy[1]), .err(err[1]),
        .sclk(sclk[1]), .mosi(mosi[1]), .miso(miso), .cs_n(csn[1]));

    // Behavioural SPI NOR flash attached to whichever bridge is selected
    typedef struct { int len; logic [63:0] bits; longint ts; longint te; } frame_t;
    frame_t      fr[$];
    logic [7:0]  mem [int];
    logic [63:0] sh = '0;
    logic [7:0]  fc = '0, fv;
    logic [23:0] fa = '0;
    int          nb = 0, fi, polls = 0, wip_polls = 0, nstart = 0;
    longint      t_start = 0;
    wire         msclk = sel ? sclk[1] : sclk[0];
    wire         mmosi = sel ? mosi[1] : mosi[0];
    wire         mcsn  = sel ? csn[1] : csn[0];

    function automatic logic [7:0] mem_rd(int a);
        return mem.exists(a) ? mem[a] : 8'(a ^ (a >> 8) ^ 32'h5A);
    endfunction

    always @(negedge mcsn) begin
        nb = 0; sh = '0; fc = '0; t_start = $time; nstart++;
    end
    always @(posedge msclk) if (!mcsn) begin
        sh = {sh[62:0], mmosi}; nb++;
        if (nb == 8) fc = sh[7:0];
        if (nb == 32) fa = sh[23:0];
    end
    always @(negedge msclk) if (!mcsn) begin
        fv = (fc == 8'h03 && nb >= 32) ? mem_rd(int'(fa)) :
             (fc == 8'h05 && nb >= 8) ? {7'd0, polls < wip_polls} : 8'h00;
        fi = fc == 8'h03 ? nb - 32 : nb - 8;
        miso = (fi >= 0 && fi < 8) ? fv[7 - fi] : 1'b0;
    end
    always @(posedge mcsn) begin
        fr.push_back('{nb, sh, t_start, $time});
        if (nb == 40 && sh[39:32] == 8'h02) begin
            mem[int'(sh[31:8])] = sh[7:0];
            polls = 0;
        end
        if (nb == 16 && sh[15:8] == 8'h05) polls++;
    end

    always @(negedge clk) if ((rdoe[0] && busy[0]) || (rdoe[1] && busy[1])) viol++;

    function automatic logic [63:0] fb(int k);
        return k < fr.size() ? fr[k].bits : '1;
    endfunction
    function automatic int fl(int k);
        return k < fr.size() ? fr[k].len : -1;
    endfunction
    function automatic int n_polls();
        int c = 0;
        foreach (fr[k]) if (fr[k].len == 16 && fr[k].bits[15:8] == 8'h05) c++;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int i, output int lat);
        lat = 0;
        while (busy[i] && lat < 5000) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic do_read(input int i, input logic [15:0] a, output logic [7:0] rd, output int lat);
        fr.delete(); addr_r = a;
        @(posedge clk); #1; oen[i] = 1'b0;
        @(posedge clk); #1;
        chk("rd_start", {busy[i], csn[i]}, 2'b10);
        wait_idle(i, lat);
        rd = i ? rdata1 : rdata0;
    endtask

    task automatic rel_oe(input int i);
        oen[i] = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int wip, output int lat);
        fr.delete(); wip_polls = wip; addr_r = a; wdata_r = d;
        @(posedge clk); #1; wen[0] = 1'b0;
        @(posedge clk); #1;
        chk("wr_start", {busy[0], csn[0]}, 2'b10);
        wait_idle(0, lat);
        wen[0] = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0]  rd, d;
        logic [15:0] a;
        int          lat, n0, w;
        longint      te1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dut0", {rdata0, rdoe[0], busy[0], err[0], sclk[0], mosi[0], csn[0]}, 14'h0001);
        chk("rst_dut1", {rdata1, rdoe[1], busy[1], err[1], sclk[1], mosi[1], csn[1]}, 14'h0001);
        rst = 1'b0;
        // directed read
        mem[32'h1234] = 8'hA5;
        do_read(0, 16'h1234, rd, lat);
        chk("rd_data", rd, 8'hA5);
        chk("rd_latency", lat, 162);
        chk("rd_frames", fr.size(), 1);
        chk("rd_len", fl(0), 40);
        chk("rd_hdr", fb(0) >> 8, 64'h0300_1234);
        chk("rd_oe_on", rdoe[0], 1'b1);
        rel_oe(0);
        chk("rd_oe_off", rdoe[0], 1'b0);
        chk("rd_hold", rdata0, 8'hA5);
        // random reads
        for (int k = 0; k < 4; k++) begin
            a = 16'($urandom); d = 8'($urandom);
            mem[int'(a)] = d;
            do_read(0, a, rd, lat);
            chk("rnd_rd_data", rd, d);
            chk("rnd_rd_latency", lat, 162);
            chk("rnd_rd_hdr", fb(0) >> 8, {40'h03_00, a});
            rel_oe(0);
        end
        // directed write, 3 busy polls
        do_write(16'h8001, 8'h3C, 3, lat);
        chk("wr_done", lat < 5000, 1'b1);
        chk("wr_frames", fr.size(), 6);
        chk("wr_wren", {fl(0), fb(0)}, {32'd8, 64'h06});
        chk("wr_pp", {fl(1), fb(1)}, {32'd40, 64'h02_0080_013C});
        chk("wr_gap", fr.size() > 1 && fr[1].ts - fr[0].te >= 4 * PER, 1'b1);
        chk("wr_polls", n_polls(), 4);
        chk("wr_err", err[0], 1'b0);
        do_read(0, 16'h8001, rd, lat);
        chk("wr_readback", rd, 8'h3C);
        rel_oe(0);
        // random writes with random busy time
        for (int k = 0; k < 2; k++) begin
            a = 16'($urandom); d = 8'($urandom); w = int'($urandom_range(0, 2));
            do_write(a, d, w, lat);
            chk("rnd_wr_pp", fb(1), {24'h0, 8'h02, 8'h00, a, d});
            chk("rnd_wr_polls", n_polls(), w + 1);
            do_read(0, a, rd, lat);
            chk("rnd_wr_readback", rd, d);
            rel_oe(0);
        end
        // write timeout
        do_write(16'h0777, 8'h11, 1000000, lat);
        chk("to_done", busy[0], 1'b0);
        chk("to_polls", n_polls(), 4);
        chk("to_err", err[0], 1'b1);
        do_read(0, 16'h1234, rd, lat);
        rel_oe(0);
        chk("to_err_sticky", err[0], 1'b1);
        // both strobes together, then strobe toggles while busy
        n0 = nstart;
        @(posedge clk); #1; oen[0] = 1'b0; wen[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("both_low", {nstart - n0, 31'd0, busy[0], csn[0]}, {32'd0, 31'd0, 2'b01});
        oen[0] = 1'b1; wen[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n0 = nstart; addr_r = 16'h1234;
        oen[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1; oen[0] = 1'b1; wen[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1; oen[0] = 1'b0; wen[0] = 1'b1;
        wait_idle(0, lat);
        repeat (20) @(posedge clk);
        #1;
        chk("toggle_frames", nstart - n0, 1);
        chk("toggle_data", rdata0, 8'hA5);
        rel_oe(0);
        // reset during page program
        fr.delete(); wip_polls = 0; addr_r = 16'h4242; wdata_r = 8'h99;
        @(posedge clk); #1; wen[0] = 1'b0;
        n0 = 0;
        while (!(fr.size() == 1 && nb >= 20) && n0 < 2000) begin
            @(posedge clk); #1; n0++;
        end
        chk("pp_bit20", n0 < 2000, 1'b1);
        rst = 1'b1; wen[0] = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid", {csn[0], busy[0], sclk[0], mosi[0], err[0]}, 5'b10000);
        rst = 1'b0;
        a = 16'hBEEF; mem[int'(a)] = 8'h5C;
        do_read(0, a, rd, lat);
        chk("post_rst_data", rd, 8'h5C);
        chk("post_rst_latency", lat, 162);
        rel_oe(0);
        // CLK_DIV=1 back-to-back reads
        sel = 1'b1;
        a = 16'($urandom); d = 8'($urandom); mem[int'(a)] = d;
        do_read(1, a, rd, lat);
        chk("fast_rd0", {rd, 32'(lat), 32'(fl(0))}, {d, 32'd82, 32'd40});
        chk("fast_hdr0", fb(0) >> 8, {40'h03_00, a});
        te1 = fr.size() > 0 ? fr[0].te : 0;
        rel_oe(1);
        a = 16'($urandom); d = 8'($urandom); mem[int'(a)] = d;
        do_read(1, a, rd, lat);
        chk("fast_rd1", {rd, 32'(lat), 32'(fl(0))}, {d, 32'd82, 32'd40});
        chk("fast_hdr1", fb(0) >> 8, {40'h03_00, a});
        chk("fast_gap", fr.size() > 0 && fr[0].ts - te1 >= PER, 1'b1);
        rel_oe(1);
        chk("oe_never_busy", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
